minterm_lut_pipe: RTL
=====================

Name: minterm_lut_pipe

Overview:
Parametrised, pipelined successor to the team's fixed 3-input sum-of-minterms logic. It evaluates N_CH independent N_IN-input Boolean functions. Each function is held as a run-time-programmable truth table. A 2-stage valid/ready pipeline replaces the old fixed gate delays with registered, cycle-accurate latency. It sits between a producer of input vectors and a consumer of 1-bit-per-channel results.

Parameters:
N_IN, 3, inputs per channel; legal range 1..6.
N_CH, 4, number of independent channels.
TT_W, 2**N_IN, truth-table width (derived; do not override).
DEFAULT_TT, 'h31, reset truth table loaded into every channel, zero-extended or truncated to TT_W. For N_IN=3 this is f = a'b'c' | ab'c' | ab'c.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cfg_we  in  1  truth-table write strobe.
cfg_ch  in  $clog2(N_CH) (min 1)  channel selected for the write.
cfg_tt  in  TT_W  new truth table; bit k is the output for input index k.
in_valid  in  1  input vector valid.
in_ready  out  1  block can accept the input vector.
in_data  in  N_CH*N_IN  channel c occupies [c*N_IN +: N_IN]; the MSB of each slice is "a".
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_y  out  N_CH  bit c is the result for channel c.

Behaviour:
- Reset (async assert, deassert sampled on clk): s1_valid=0, s2_valid=0, out_valid=0, out_y=0. Every channel table = DEFAULT_TT. in_ready=1 once reset is released.
- Handshake: a transfer occurs when valid&&ready on the same rising edge. After in_valid is raised, in_data must stay stable until the transfer; the same holds for out_y with respect to out_valid. out_valid does not depend combinationally on out_ready.
- Stage 1 (capture): on an input transfer, register the in_data slices as per-channel indices and set s1_valid.
- Stage 2 (lookup): when stage 1 advances, out_y[c] <= table[c][idx1[c]] and s2_valid <= 1. out_valid = s2_valid.
- Latency: exactly 2 clk edges from input transfer to out_valid, with out_ready held at 1. Throughput is 1 vector per cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; one-deep per stage, no skid buffer).
- Stall: with out_ready=0 and both stages full, in_ready=0 and all pipeline registers hold. When out_ready returns to 1, the pipeline drains in order with no loss or duplication.
- Bubble: if s2 is consumed while s1 is empty, s2_valid <= 0.
- Config write: when cfg_we=1, table[cfg_ch] <= cfg_tt at that edge.
  - A lookup on the same edge uses the OLD table.
  - Lookups from the next edge on use the new table.
  - Writes are legal at any time, including during stalls.
  - Any result already held in stage 2 is not recomputed.
- Out-of-range cfg_ch (>= N_CH, when N_CH is not a power of 2): the write is ignored.
- Simultaneous cfg writes to the same channel are impossible; there is a single write port.
- Reset mid-operation: in-flight vectors are discarded and tables revert to DEFAULT_TT. No output transfer occurs in the reset cycle.
- Index width: exactly N_IN bits, so there is no out-of-range lookup.

Decomposition:
- Package minterm_lut_pkg holds:
  - the function tt_width(n) = 2**n;
  - the localparam DEFAULT_TT_3IN = 8'h31;
  - the typedef for the per-channel index.
- Sub-module lut_cell: one channel's table register plus write enable, with a combinational read by index. It is instantiated N_CH times from a generate loop.
- The pipeline control (s1/s2 valid, advance logic) stays in the top level.

Test Plan:
1. Reset default, N_IN=3, N_CH=4: apply inputs {a,b,c}=000,001,010,011,100,101,110,111 on channel 0 with out_ready=1 -> out_y[0] = 1,0,0,0,1,1,0,0, each 2 cycles after its transfer.
2. Back-to-back streaming: 16 consecutive vectors with in_valid held high -> in_ready stays 1, 16 results with out_valid high on 16 consecutive cycles, in order.
3. Backpressure: out_ready=0 for 5 cycles while feeding -> in_ready falls after 2 accepted vectors; out_y stays stable. After release, all vectors emerge in order with no drops.
4. Reprogram: write cfg_ch=2, cfg_tt=8'h80 in the same cycle as a transfer of 111 -> that result uses the old table (out_y[2]=0); the next 111 gives out_y[2]=1; other channels are unchanged.
5. Async reset mid-stream: assert reset between edges with both stages full -> out_valid=0 immediately; after release, the tables read 'h31 again.
6. Parameter sweep N_IN=1, N_CH=1 with cfg_tt=2'b10 -> out_y = input (identity); out-of-range cfg_ch at N_CH=3 is ignored.

Source files
------------

// File: rtl/minterm_lut_pkg.sv
// minterm_lut_pkg: shared types and helpers
// for the programmable minterm LUT pipeline.
package minterm_lut_pkg;

  localparam int MAX_IN = 6;

  localparam logic [7:0] DEFAULT_TT_3IN = 8'h31;

  typedef logic [MAX_IN-1:0] idx_t;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/minterm_lut_pipe_lut_cell.sv
// lut_cell: one channel's truth table register
// with a write port and combinational read.
module lut_cell
  import minterm_lut_pkg::*;
#(
  parameter int              TT_W   = 8,
  parameter logic [TT_W-1:0] RST_TT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [TT_W-1:0] tt,
  input  idx_t            idx,
  output logic            y
);

  logic [TT_W-1:0] tt_q;
  logic [63:0]     tt_x;

  // table register, reloaded with the default on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tt_q <= RST_TT;
    end else if (we) begin
      tt_q <= tt;
    end
  end

  // index upper bits are always zero, so the
  // widened table never returns padding
  assign tt_x = 64'(tt_q);
  assign y    = tt_x[idx];

endmodule

// File: rtl/minterm_lut_pipe.sv
// minterm_lut_pipe: N_CH run-time programmable
// N_IN-input functions behind a 2-stage pipe.
module minterm_lut_pipe
  import minterm_lut_pkg::*;
#(
  parameter int          N_IN       = 3,
  parameter int          N_CH       = 4,
  parameter int          TT_W       = tt_width(N_IN),
  parameter logic [63:0] DEFAULT_TT = 64'(DEFAULT_TT_3IN),
  localparam int         CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [TT_W-1:0]      cfg_tt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*N_IN-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH-1:0]      out_y
);

  logic            s1_valid;
  logic            s2_valid;
  logic            s1_adv;
  logic            s2_adv;
  idx_t            idx1 [N_CH];
  logic [N_CH-1:0] look;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lut_cell #(
      .TT_W   (TT_W),
      .RST_TT (DEFAULT_TT[TT_W-1:0])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .we    (cfg_we && (cfg_ch == CW'(c))),
      .tt    (cfg_tt),
      .idx   (idx1[c]),
      .y     (look[c])
    );
  end

  // stage 1: capture per-channel indices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        idx1[c] <= '0;
      end
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int c = 0; c < N_CH; c++) begin
          idx1[c] <= idx_t'(in_data[c*N_IN +: N_IN]);
        end
      end
    end
  end

  // stage 2: table lookup into the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_y    <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv) begin
        out_y <= look;
      end
    end
  end

endmodule
